seq_bit_serializer: RTL

//   Upstream feeder for the sequence-detector FSMs. Accepts parallel words over a

---
 rtl/seq_bit_serializer.sv | 92 +++++++++
 1 files changed

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detectors: takes words over valid/ready
// and streams them one bit per clock with no gap between back-to-back words.
module seq_bit_serializer #(
  parameter int       WIDTH     = 8,
  parameter int       MSB_FIRST = 1,
  parameter logic     IDLE_BIT  = 1'b0,
  parameter int       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             hold,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int RW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [RW-1:0]    rem, rem_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             ser_out_n;
  logic             ser_valid_n;
  logic [CNT_W-1:0] words_sent_n;
  logic             emit;
  logic             accept;
  logic             next_bit;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      shreg      <= '0;
      ser_out    <= IDLE_BIT;
      ser_valid  <= 1'b0;
      words_sent <= '0;
    end else begin
      state      <= state_n;
      rem        <= rem_n;
      shreg      <= shreg_n;
      ser_out    <= ser_out_n;
      ser_valid  <= ser_valid_n;
      words_sent <= words_sent_n;
    end
  end

  always_comb begin
    emit         = (state == SHIFT) & ~hold;
    // Ready on the last-bit edge lets the next word load with no idle cycle.
    word_ready   = (state == IDLE) | ((rem == RW'(1)) & ~hold);
    accept       = word_valid & word_ready;
    next_bit     = IDLE_BIT;
    shifted      = shreg;
    if (MSB_FIRST != 0) begin
      next_bit = shreg[WIDTH-1];
      shifted  = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      next_bit = shreg[0];
      shifted  = {1'b0, shreg[WIDTH-1:1]};
    end

    rem_n        = rem;
    shreg_n      = shreg;
    ser_out_n    = IDLE_BIT;
    ser_valid_n  = 1'b0;
    words_sent_n = words_sent;

    if (emit) begin
      ser_out_n   = next_bit;
      ser_valid_n = 1'b1;
      rem_n       = rem - RW'(1);
      shreg_n     = shifted;
      if (rem == RW'(1))
        words_sent_n = words_sent + CNT_W'(1);
    end
    if (accept) begin
      shreg_n = word_in;
      rem_n   = RW'(WIDTH);
    end

    state_n = (rem_n != '0) ? SHIFT : IDLE;
    busy    = (state == SHIFT) | ser_valid;
  end

endmodule
